// File: rtl/md_unit.sv
// Multiply/divide unit holding the HI/LO pair, with fixed-latency busy/stall and cancel.
// Define MD_MSUB_EN to enable MSUB (subtract the signed product from {HI,LO}).
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             madd,
  input  logic             msub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_we,
  input  logic             mt_hi,
  input  logic             rd_hi,
  input  logic             cancel,
  input  logic             md_use,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int W2   = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [1:0]       op_q, op_d;
  logic             madd_q, madd_d, msub_q, msub_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    hilo, prod_u, prod_s, res;
  logic [WIDTH-1:0] b_safe, q_u, r_u;
  logic signed [WIDTH-1:0] q_s, r_s;
  logic             div_ovf;

`ifndef MD_MSUB_EN
  logic unused_msub;
  assign unused_msub = msub;
`endif

  assign busy    = (cnt_q != '0);
  assign stall   = md_use & (busy | start);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_hi ? hi_q : lo_q;
  assign hilo    = {hi_q, lo_q};

  // Sign-extended operands multiplied modulo 2^(2W) yield the signed product bits.
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

  assign div_ovf = op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == {WIDTH{1'b1}});
  // Divisor is forced to 1 on the special cases so the divider never sees /0 or overflow.
  assign b_safe  = ((b_q == '0) || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
  assign q_u     = a_q / b_safe;
  assign r_u     = a_q % b_safe;
  assign q_s     = $signed(a_q) / $signed(b_safe);
  assign r_s     = $signed(a_q) % $signed(b_safe);

  always_comb begin
    res = prod_u;
    case (op_q)
      2'b00: res = prod_u;
      2'b01: begin
`ifdef MD_MSUB_EN
        if (msub_q)      res = hilo - prod_s;
        else if (madd_q) res = hilo + prod_s;
        else             res = prod_s;
`else
        res = madd_q ? (hilo + prod_s) : prod_s;
`endif
      end
      default: begin
        if (b_q == '0)   res = {a_q, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, a_q};
        else if (op_q[0]) res = {r_s, q_s};
        else             res = {r_u, q_u};
      end
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    madd_d = madd_q;
    msub_d = msub_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (cancel) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) {hi_d, lo_d} = res;
    end else if (start) begin
      a_d    = a;
      b_d    = b;
      op_d   = op;
      madd_d = madd;
      msub_d = msub;
      cnt_d  = op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end
    if (mt_we && !busy && !start) begin
      if (mt_hi) hi_d = a;
      else       lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      madd_q <= 1'b0;
      msub_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      madd_q <= madd_d;
      msub_q <= msub_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with hand-computed HI/LO expectations.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, madd, msub, mt_we, mt_hi, rd_hi, cancel, md_use;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo, rd_data;
  int          vectors = 0;
  int          miscompares = 0;
  int          n;

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .madd(madd), .msub(msub),
    .a(a), .b(b), .mt_we(mt_we), .mt_hi(mt_hi), .rd_hi(rd_hi), .cancel(cancel),
    .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic md, input logic ms, output int cnt);
    op = o; a = av; b = bv; madd = md; msub = ms; start = 1'b1;
    tick();
    start = 1'b0; madd = 1'b0; msub = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; madd = 1'b0; msub = 1'b0; mt_we = 1'b0; mt_hi = 1'b0;
    rd_hi = 1'b0; cancel = 1'b0; md_use = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    check("reset_busy", busy, 0);
    check_hilo("reset", 32'h0, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // MULT -3*5 with stall observation
    md_use = 1'b1; #1;
    check("idle_stall", stall, 0);
    op = 2'b01; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1; #1;
    check("start_stall", stall, 1);
    tick();
    start = 1'b0; #1;
    check("busy_stall", stall, 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    md_use = 1'b0;
    check("mult_lat", n, 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n);
    check("div_lat", n, 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    rd_hi = 1'b1; #1;
    check("rd_hi", rd_data, 32'hFFFF_FFFF);
    rd_hi = 1'b0; #1;
    check("rd_lo", rd_data, 32'hFFFF_FFFD);

    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);
    run_op(2'b11, 32'hFFFF_FFFB, 32'h0, 1'b0, 1'b0, n);
    check_hilo("div_zero", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h0000_1234, 32'h0, 1'b0, 1'b0, n);
    check_hilo("divu_zero", 32'h0000_1234, 32'hFFFF_FFFF);
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, n);
    check_hilo("divu", 32'd2, 32'd14);

    // MTHI / MTLO then MADD / MSUB
    mt_we = 1'b1; mt_hi = 1'b1; a = 32'd1; tick();
    mt_hi = 1'b0; a = 32'hFFFF_FFFF; tick();
    mt_we = 1'b0;
    check_hilo("mt", 32'd1, 32'hFFFF_FFFF);
    run_op(2'b01, 32'd1, 32'd1, 1'b1, 1'b0, n);
    check("madd_lat", n, 5);
    check_hilo("madd", 32'd2, 32'd0);
    run_op(2'b01, 32'd1, 32'd1, 1'b0, 1'b1, n);
`ifdef MD_MSUB_EN
    check_hilo("msub", 32'd1, 32'hFFFF_FFFF);
`else
    check_hilo("msub_off", 32'd0, 32'd1);
`endif
    mt_we = 1'b1; mt_hi = 1'b1; a = 32'd0; tick();
    mt_hi = 1'b0; a = 32'd5; tick();
    mt_we = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, 1'b1, 1'b1, n);
`ifdef MD_MSUB_EN
    check_hilo("msub_wins", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    check_hilo("madd_both", 32'd0, 32'd11);
`endif
    run_op(2'b00, 32'd2, 32'd3, 1'b1, 1'b0, n);
    check_hilo("madd_op00", 32'd0, 32'd6);

    // mt_we held through start and busy must be ignored
    mt_we = 1'b1; mt_hi = 1'b1;
    run_op(2'b00, 32'h0000_DEAD, 32'd2, 1'b0, 1'b0, n);
    mt_we = 1'b0;
    check_hilo("mt_vs_start", 32'd0, 32'h0001_BD5A);

    // cancel in busy cycle 3
    op = 2'b00; a = 32'd7; b = 32'd9; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    cancel = 1'b1; tick();
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    repeat (8) tick();
    check_hilo("cancel", 32'd0, 32'h0001_BD5A);

    // cancel on the completion cycle
    start = 1'b1; tick();
    start = 1'b0; repeat (4) tick();
    check("pre_done_busy", busy, 1);
    cancel = 1'b1; tick();
    cancel = 1'b0;
    check("cancel_done_busy", busy, 0);
    check_hilo("cancel_done", 32'd0, 32'h0001_BD5A);

    // cancel together with start
    start = 1'b1; cancel = 1'b1; tick();
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", busy, 0);
    repeat (6) tick();
    check_hilo("cancel_start", 32'd0, 32'h0001_BD5A);

    // asynchronous reset in the middle of a DIV
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    #1 rst_n = 1'b0; #1;
    check("rst_mid_busy", busy, 0);
    check_hilo("rst_mid", 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check_hilo("rst_after", 32'd0, 32'd0);
    run_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, n);
    check("post_rst_lat", n, 5);
    check_hilo("post_rst", 32'd0, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit holding the HI/LO register pair.
- Sits in the EX stage and is driven by the decoder's mult/div control signals (start, op, write, HI/LO select, read).
- Extends those signals with configurable width and latency, MADD accumulation, a busy/stall interface and exception cancel.
- The decode stage stalls on the `stall` output while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=8).
- MULT_LAT, 5, cycles busy for MULT/MULTU/MADD (>=1).
- DIV_LAT, 10, cycles busy for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin operation (EX stage).
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- madd  in  1  with start and op=01: accumulate signed product into {HI,LO}.
- msub  in  1  see Optional Feature.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- mt_we  in  1  MTHI/MTLO write.
- mt_hi  in  1  1=MTHI, 0=MTLO.
- rd_hi  in  1  read select: 1=HI, 0=LO.
- cancel  in  1  exception flush: abort in-flight op.
- md_use  in  1  decode-stage instruction is any HI/LO or mult/div instruction.
- busy  out  1  operation in flight.
- stall  out  1  stall request to decode.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd_data  out  WIDTH  rd_hi ? hi : lo (combinational).

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, latched operands/op cleared. Asynchronous assertion; takes effect mid-operation with no result written.
- Idle start (busy=0 and start=1):
  - Latch a, b, op, madd, msub.
  - Load counter with MULT_LAT (op 0x) or DIV_LAT (op 1x).
  - busy=1 from the next cycle.
- Counting: busy = (counter!=0); counter decrements each cycle.
- Result write: on the edge where counter goes 1->0, HI/LO are written and busy falls. busy is high for exactly LAT cycles.
- start while busy: ignored; stall is expected to prevent it.
- MULTU: {HI,LO} = unsigned a*b, 2*WIDTH bits.
- MULT: {HI,LO} = signed a*b.
- MADD: {HI,LO} = {HI,LO} + signed a*b, modulo 2^(2*WIDTH). Uses HI/LO values at result-write time.
- madd with op!=01: ignored; the plain op is executed.
- DIVU: LO = quotient, HI = remainder.
- DIV:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow (a = -2^(WIDTH-1), b = -1): LO = a, HI = 0.
- Divide by zero (DIV or DIVU): LO = all ones, HI = a.
- mt_we:
  - Honoured only when busy=0 and start=0; writes a to HI (mt_hi=1) or LO (mt_hi=0) at the edge.
  - Otherwise ignored.
  - The same-cycle start takes precedence.
- cancel:
  - Synchronous. Clears counter and busy at the next edge; HI/LO unchanged.
  - cancel with start in the same cycle: start is not accepted.
  - cancel on the completion cycle: result is not written.
- stall = md_use & (busy | start): combinational. Covers back-to-back md instructions.
- rd_data and hi/lo are registered values only; no bypass of an in-flight result.

Optional Feature:
- Macro MD_MSUB_EN.
- Defined: start with op=01 and msub=1 gives {HI,LO} = {HI,LO} - signed a*b, modulo 2^(2*WIDTH). madd and msub both 1: msub wins.
- Undefined: msub port exists but is ignored; such a start behaves per madd/op.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; md_use during busy -> stall=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234.
- MTHI 1, MTLO 0xFFFFFFFF, then MADD a=1, b=1 -> hi=2, lo=0. With MD_MSUB_EN, MSUB a=1, b=1 -> hi=1, lo=0xFFFFFFFF.
- MULTU started, cancel at busy cycle 3 -> busy=0 next cycle, HI/LO unchanged. mt_we with start in the same cycle -> mt ignored.
- rst_n low for one cycle mid-DIV -> hi=lo=0, busy=0 immediately. Later start accepted normally.
